kypd_emulator: RTL and testbench

- Emulates a 16-key Pmod keypad from the device side of the scan interface. It samples the column strobes driven by a keypad scanner and drives the row returns as if keys were physically pressed.
- Key presses are scripted through a small command FIFO (key index, hold time) and executed one at a time.
- Used on a second Pmod port (or in simulation) to exercise the mole-button scanner without a human player.

---
 rtl/kypd_emulator.sv | 133 +++++++++++++
 tb/tb_kypd_emulator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kypd_emulator.sv
// Device-side 16-key keypad model: scripted presses from a command FIFO drive active-low rows against sampled column strobes.
// row_n follows col_n 3 edges later and pressed 1 edge later; cmd_ready drops only when the FIFO is full.
module kypd_emulator #(
    parameter int CLK_HZ     = 100000000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MS     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [7:0]  cmd_hold_ms,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [15:0] pressed,
    output logic        busy,
    output logic        done
);
    localparam int TICK_CYC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam logic [15:0] GAP_LD = 16'(GAP_MS);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
    typedef struct packed {
        logic [3:0] key;
        logic [7:0] hold;
    } cmd_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    cmd_t          head;

    state_t        state, state_next;
    logic [PW-1:0] pre_cnt;
    logic          tick, last_ms;
    logic [15:0]   ms_left;
    logic [3:0]    col_m, col_s;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_key, cmd_hold_ms};
    end

    assign tick    = (pre_cnt == PW'(TICK_CYC - 1));
    assign last_ms = tick && (ms_left == 16'd1);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = PRESS;
                end
            end
            PRESS:   if (last_ms) state_next = (GAP_MS == 0) ? IDLE : GAP;
            GAP:     if (last_ms) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Prescaler restarts on every state entry so each ms count is cycle-exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pre_cnt <= '0;
            ms_left <= '0;
            pressed <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if ((state_next != state) || tick) pre_cnt <= '0;
            else                               pre_cnt <= pre_cnt + PW'(1);
            case (state)
                IDLE: begin
                    if (pop) begin
                        pressed <= 16'd1 << head.key;
                        ms_left <= (head.hold == 8'd0) ? 16'd1 : {8'd0, head.hold};
                    end
                end
                PRESS: begin
                    if (last_ms) begin
                        pressed <= '0;
                        done    <= 1'b1;
                        ms_left <= GAP_LD;
                    end else if (tick) begin
                        ms_left <= ms_left - 16'd1;
                    end
                end
                GAP:     if (tick) ms_left <= ms_left - 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
            row_n <= 4'hF;
        end else begin
            col_m <= col_n;
            col_s <= col_m;
            for (int r = 0; r < 4; r++)
                row_n[r] <= ~|(pressed[r*4 +: 4] & ~col_s);
        end
    end
endmodule

// File: tb/tb_kypd_emulator.sv
// Bench for kypd_emulator: timeline model of presses/gaps plus directed scenarios.
module tb_kypd_emulator;
    localparam int CLK_HZ = 10000;
    localparam int DEPTH  = 4;
    localparam int GAP_MS = 2;
    localparam int TICK   = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_key = 4'd0;
    logic [7:0]  cmd_hold_ms = 8'd0;
    logic [3:0]  col_n = 4'hF;
    logic        cmd_ready, busy, done;
    logic [3:0]  row_n;
    logic [15:0] pressed;

    int checks = 0;
    int failures = 0;

    kypd_emulator #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .GAP_MS(GAP_MS)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key(cmd_key), .cmd_hold_ms(cmd_hold_ms), .col_n(col_n),
        .row_n(row_n), .pressed(pressed), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    // which: 0 done high, 1 busy low, 2 pressed nonzero, 3 cmd_ready high
    task automatic wait_for(input int which, input int bound, output int n);
        n = 0;
        forever begin
            if ((which == 0 && done) || (which == 1 && !busy) ||
                (which == 2 && pressed != 0) || (which == 3 && cmd_ready)) return;
            if (n >= bound) begin
                checks++;
                failures++;
                $display("FAIL timeout_wait%0d actual=%0d cycles required=<%0d", which, n, bound);
                return;
            end
            cyc(1);
            n++;
        end
    endtask

    // Timeline model: each command occupies [start, start+hold*TICK) pressed, then GAP_MS*TICK of gap.
    typedef struct packed {
        logic [3:0] key;
        logic [7:0] hold;
    } mcmd_t;

    logic [15:0] exp_pressed = '0;
    logic [3:0]  exp_row = 4'hF;
    logic        exp_done = 1'b0, exp_busy = 1'b0, exp_ready = 1'b1;

    initial begin
        mcmd_t      mq[$];
        mcmd_t      c;
        int         n, start_e, rel_e, idle_e, h;
        logic [15:0] mask;
        logic [3:0] col_h1, col_h2;
        bit         do_pop, do_push;
        n = 0; start_e = -1; rel_e = -1; idle_e = -1; mask = '0;
        col_h1 = 4'hF; col_h2 = 4'hF;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                n = 0; start_e = -1; rel_e = -1; idle_e = -1; mask = '0;
                col_h1 = 4'hF; col_h2 = 4'hF;
                exp_pressed = '0; exp_row = 4'hF; exp_done = 1'b0;
                exp_busy = 1'b0; exp_ready = 1'b1;
            end else begin
                do_pop  = (n > idle_e) && (mq.size() > 0);
                do_push = cmd_valid && (mq.size() < DEPTH);
                for (int r = 0; r < 4; r++)
                    exp_row[r] = ~|(exp_pressed[r*4 +: 4] & ~col_h2);
                col_h2 = col_h1;
                col_h1 = col_n;
                if (do_pop) begin
                    c       = mq.pop_front();
                    h       = (c.hold == 0) ? 1 : int'(c.hold);
                    start_e = n;
                    rel_e   = n + h * TICK;
                    idle_e  = rel_e + GAP_MS * TICK;
                    mask    = 16'd1 << c.key;
                end
                if (do_push) mq.push_back({cmd_key, cmd_hold_ms});
                exp_pressed = (n >= start_e && n < rel_e) ? mask : 16'd0;
                exp_done    = (n == rel_e);
                exp_busy    = (n < idle_e) || (mq.size() > 0);
                exp_ready   = (mq.size() < DEPTH);
                n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cmp_pressed", pressed, exp_pressed);
                chk("cmp_row_n", row_n, exp_row);
                chk("cmp_done", done, exp_done);
                chk("cmp_busy", busy, exp_busy);
                chk("cmp_cmd_ready", cmd_ready, exp_ready);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, cnt, ndone, idx;
        logic [15:0] prevp;
        logic [3:0]  keys  [5] = '{4'd9, 4'd3, 4'd12, 4'd0, 4'd5};
        logic [7:0]  holds [5] = '{8'd1, 8'd0, 8'd1, 8'd2, 8'd1};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_row_n", row_n, 4'hF);
        chk("rst_pressed", pressed, 16'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        cyc(3);

        // Key 6 held 3 ms with its column strobed
        col_n = 4'b1011;
        cyc(3);
        cmd_key = 4'd6; cmd_hold_ms = 8'd3; cmd_valid = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
        chk("push_pressed_before_pop", pressed, 16'h0);
        cyc(1);
        chk("press_mask", pressed, 16'h0040);
        chk("press_row_lag", row_n, 4'hF);
        cyc(1);
        chk("press_row", row_n, 4'b1101);
        wait_for(0, 100, n);
        chk_rng("hold_len", n + 1, 29, 31);
        chk("release_pressed", pressed, 16'h0);
        chk("release_row_lag", row_n, 4'b1101);
        cyc(3);
        chk("release_row", row_n, 4'hF);
        wait_for(1, 100, n);
        chk_rng("gap_len", n + 3, 19, 21);

        // Wrong column, then the right one mid-press
        col_n = 4'b1110;
        cyc(3);
        cmd_key = 4'd6; cmd_hold_ms = 8'd3; cmd_valid = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(5);
        chk("wrong_col_pressed", pressed, 16'h0040);
        chk("wrong_col_row", row_n, 4'hF);
        col_n = 4'b1011;
        cyc(2);
        chk("col_latency_2", row_n, 4'hF);
        cyc(1);
        chk("col_latency_3", row_n, 4'b1101);
        wait_for(0, 100, n);

        // Burst of 5 pushes during the gap
        for (int i = 0; i < 5; i++) begin
            cmd_key = keys[i]; cmd_hold_ms = holds[i]; cmd_valid = 1'b1;
            wait_for(3, 200, n);
            cyc(1);
            if (i == 3) chk("full_after_4", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        cnt = 0; ndone = 0; idx = 0; prevp = '0;
        while (busy && cnt < 600) begin
            if (pressed != 0 && pressed != prevp) begin
                if (idx < 5) chk("burst_order", pressed, 16'd1 << keys[idx]);
                else         chk("burst_extra_press", pressed, 16'h0);
                idx++;
            end
            prevp = pressed;
            if (done) ndone++;
            cyc(1);
            cnt++;
        end
        if (cnt >= 600) begin
            checks++; failures++;
            $display("FAIL timeout_burst actual=%0d cycles required=<600", cnt);
        end
        chk("burst_presses", idx, 5);
        chk("burst_dones", ndone, 5);

        // hold=0 acts as 1 ms; key 15 on column 3
        col_n = 4'b0111;
        cyc(3);
        cmd_key = 4'd15; cmd_hold_ms = 8'd0; cmd_valid = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
        wait_for(2, 20, n);
        chk("key15_mask", pressed, 16'h8000);
        cyc(2);
        chk("key15_row", row_n, 4'b0111);
        wait_for(0, 50, n);
        chk_rng("hold0_len", n + 2, 9, 11);
        wait_for(1, 100, n);

        // Reset mid-press with two commands queued
        col_n = 4'b1101;
        cyc(3);
        cmd_key = 4'd5; cmd_hold_ms = 8'd5; cmd_valid = 1'b1;
        cyc(1);
        cmd_key = 4'd2; cmd_hold_ms = 8'd1;
        cyc(1);
        cmd_key = 4'd7; cmd_hold_ms = 8'd1;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(10);
        chk("pre_rst_row", row_n, 4'b1101);
        chk("pre_rst_pressed", pressed, 16'h0020);
        rst = 1'b1;
        #1;
        chk("midrst_pressed", pressed, 16'h0);
        chk("midrst_row", row_n, 4'hF);
        chk("midrst_done", done, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_busy", busy, 1'b0);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) ndone++;
            cyc(1);
        end
        chk("post_rst_dones", ndone, 0);
        chk("post_rst_pressed", pressed, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
